// File: rtl/llr_wb_buffer_if.sv
// ----------------------------------------------------------------------------
// llr_wb_buffer_if
//
// Bundles the signals between the PE array, the LLR write-back buffer and the
// LLR memory write port.
//
// Signals
//   in_valid  : PE-array result word present this cycle
//   in_data   : PE-array result, P lanes of Q bits, lane i at [(i+1)*Q-1 : i*Q]
//   in_addr   : LLR memory destination address for in_data
//   flush     : synchronous discard of everything queued in the buffer
//   in_ready  : buffer can accept a word this cycle
//   mem_we    : write request to the LLR memory port
//   mem_addr  : write address (0 while mem_we is low)
//   mem_wdata : write data (0 while mem_we is low)
//   mem_ready : memory arbiter grants the write this cycle
//   count     : number of occupied buffer entries
//   drop_err  : sticky flag, an input word was lost
//
// Modports
//   master : the surrounding logic (PE array side plus memory arbiter)
//   slave  : the write-back buffer itself
// ----------------------------------------------------------------------------
interface llr_wb_buffer_if #(
   parameter int Q     = 10,
   parameter int P     = 64,
   parameter int AW    = 6,
   parameter int DEPTH = 4
);

   logic                     in_valid;
   logic [P*Q-1:0]           in_data;
   logic [AW-1:0]            in_addr;
   logic                     flush;
   logic                     in_ready;
   logic                     mem_we;
   logic [AW-1:0]            mem_addr;
   logic [P*Q-1:0]           mem_wdata;
   logic                     mem_ready;
   logic [$clog2(DEPTH):0]   count;
   logic                     drop_err;

   // The buffer consumes words and produces memory writes and status.
   modport slave (
      input  in_valid,
      input  in_data,
      input  in_addr,
      input  flush,
      input  mem_ready,
      output in_ready,
      output mem_we,
      output mem_addr,
      output mem_wdata,
      output count,
      output drop_err
   );

   // The surroundings supply words and grants and observe the buffer.
   modport master (
      output in_valid,
      output in_data,
      output in_addr,
      output flush,
      output mem_ready,
      input  in_ready,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata,
      input  count,
      input  drop_err
   );

endinterface

// File: rtl/llr_wb_buffer.sv
// ----------------------------------------------------------------------------
// llr_wb_buffer
//
// Small circular FIFO that decouples the PE array from the LLR memory write
// port. Each entry holds one {addr, data} word. A pushed word becomes visible
// on the memory port in the cycle after it is accepted; there is never a
// combinational bypass from input to memory port.
//
// Parameters
//   Q     : LLR lane width in bits
//   P     : lanes per word
//   AW    : LLR memory address width
//   DEPTH : FIFO entries, power of two and at least 2
//
// Ports
//   clk : sole clock, all state updates on the rising edge
//   rst : asynchronous, active-high reset
//   bus : llr_wb_buffer_if.slave, handshake and memory port signals
// ----------------------------------------------------------------------------
module llr_wb_buffer #(
   parameter int Q     = 10,
   parameter int P     = 64,
   parameter int AW    = 6,
   parameter int DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst,
   llr_wb_buffer_if.slave      bus
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   // Storage array; deliberately not reset because the memory port is gated
   // to zero whenever the buffer is empty, so stale contents never escape.
   logic [AW-1:0]  addr_mem [DEPTH];
   logic [P*Q-1:0] data_mem [DEPTH];

   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  rd_ptr;
   logic [CW-1:0]  count_q;
   logic           drop_q;

   logic           full;
   logic           not_empty;
   logic           push;
   logic           pop;

   // Status is decoded from registers only so the ready path never depends on
   // mem_ready or any other same-cycle input.
   assign full      = (count_q == DEPTH_C);
   assign not_empty = (count_q != '0);

   // Flush wins over both push and pop. A pop can only happen while a write
   // is actually being requested, which makes mem_ready harmless when idle.
   assign push = bus.in_valid && !full && !bus.flush;
   assign pop  = not_empty && bus.mem_ready && !bus.flush;

   assign bus.in_ready  = !full;
   assign bus.mem_we    = not_empty;
   assign bus.count     = count_q;
   assign bus.drop_err  = drop_q;

   // Head entry is presented only while a write is requested; otherwise the
   // port is held at zero.
   assign bus.mem_addr  = not_empty ? addr_mem[rd_ptr] : '0;
   assign bus.mem_wdata = not_empty ? data_mem[rd_ptr] : '0;

   // Entry write. Pointers are PW bits wide so the DEPTH-1 -> 0 wrap falls out
   // of the natural overflow for a power-of-two depth.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[wr_ptr] <= bus.in_addr;
         data_mem[wr_ptr] <= bus.in_data;
      end
   end

   // Pointer and occupancy bookkeeping. Simultaneous push and pop leave the
   // occupancy unchanged while both pointers advance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else if (bus.flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Sticky loss flag. A word offered while full is lost even if a pop frees
   // a slot in the same cycle, because readiness was already low. A word
   // offered together with flush is discarded on purpose and is not a loss.
   // Only reset clears the flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop_q <= 1'b0;
      end else if (bus.in_valid && full && !bus.flush) begin
         drop_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_llr_wb_buffer.sv
// ----------------------------------------------------------------------------
// tb_llr_wb_buffer
//
// Directed self-checking bench for llr_wb_buffer with Q=10, P=64, AW=6,
// DEPTH=4. Inputs change and outputs are sampled 1 time unit after each
// rising clock edge.
// ----------------------------------------------------------------------------
module tb_llr_wb_buffer;

   localparam int Q     = 10;
   localparam int P     = 64;
   localparam int AW    = 6;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;
   localparam int W     = P * Q;

   logic clk;
   logic rst;

   int compared;
   int mismatched;

   llr_wb_buffer_if #(.Q(Q), .P(P), .AW(AW), .DEPTH(DEPTH)) bus ();

   llr_wb_buffer #(.Q(Q), .P(P), .AW(AW), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Distinct value per lane so any reordering or truncation is visible.
   function automatic logic [W-1:0] make_word(input int seed);
      logic [W-1:0] w;
      w = '0;
      for (int i = 0; i < P; i++) begin
         w[i*Q +: Q] = Q'((seed * 37 + i * 5) ^ (i << 4));
      end
      return w;
   endfunction

   function automatic logic [W-1:0] all_ones_word();
      logic [W-1:0] w;
      for (int i = 0; i < P; i++) begin
         w[i*Q +: Q] = 10'h3FF;
      end
      return w;
   endfunction

   // Drive all buffer inputs in one go.
   task automatic applyStimulus(input logic v, input logic [AW-1:0] a,
                                input logic [W-1:0] d, input logic mr,
                                input logic fl);
      bus.in_valid  = v;
      bus.in_addr   = a;
      bus.in_data   = d;
      bus.mem_ready = mr;
      bus.flush     = fl;
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkField(input string tag, input logic [W-1:0] obs,
                             input logic [W-1:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Compare every observable output against the expected state.
   task automatic checkOutput(input string tag, input logic we,
                              input logic [AW-1:0] addr, input logic [W-1:0] data,
                              input logic [CW-1:0] cnt, input logic rdy,
                              input logic drop);
      checkField({tag, "/mem_we"},    W'(bus.mem_we),    W'(we));
      checkField({tag, "/mem_addr"},  W'(bus.mem_addr),  W'(addr));
      checkField({tag, "/mem_wdata"}, bus.mem_wdata,     data);
      checkField({tag, "/count"},     W'(bus.count),     W'(cnt));
      checkField({tag, "/in_ready"},  W'(bus.in_ready),  W'(rdy));
      checkField({tag, "/drop_err"},  W'(bus.drop_err),  W'(drop));
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      rst = 1'b1;
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);

      // Reset state
      #2;
      checkOutput("reset", 1'b0, '0, '0, 0, 1'b1, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      // Single word, all lanes 0x3FF, one-cycle latency then drained
      applyStimulus(1'b1, 6'd5, all_ones_word(), 1'b1, 1'b0);
      step();
      checkOutput("single_out", 1'b1, 6'd5, all_ones_word(), 1, 1'b1, 1'b0);
      applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
      step();
      checkOutput("single_done", 1'b0, '0, '0, 0, 1'b1, 1'b0);

      // Fill with memory stalled; head stays at the first word
      for (int k = 1; k <= 4; k++) begin
         applyStimulus(1'b1, AW'(k), make_word(k), 1'b0, 1'b0);
         step();
         checkOutput($sformatf("fill%0d", k), 1'b1, 6'd1, make_word(1),
                     CW'(k), (k < 4), 1'b0);
      end

      // Fifth word while full is lost
      applyStimulus(1'b1, 6'd9, make_word(9), 1'b0, 1'b0);
      step();
      checkOutput("overflow", 1'b1, 6'd1, make_word(1), 4, 1'b0, 1'b1);

      // Release the memory: writes come out 1,2,3,4 in order
      applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
      for (int k = 1; k <= 4; k++) begin
         checkOutput($sformatf("drain%0d", k), 1'b1, AW'(k), make_word(k),
                     CW'(5 - k), (k != 1), 1'b1);
         step();
      end
      checkOutput("drained", 1'b0, '0, '0, 0, 1'b1, 1'b1);

      // Flush with three queued and a word offered: all discarded, flag kept
      for (int k = 10; k <= 12; k++) begin
         applyStimulus(1'b1, AW'(k), make_word(k), 1'b0, 1'b0);
         step();
      end
      checkOutput("preflush", 1'b1, 6'd10, make_word(10), 3, 1'b1, 1'b1);
      applyStimulus(1'b1, 6'd13, make_word(13), 1'b1, 1'b1);
      step();
      checkOutput("flush", 1'b0, '0, '0, 0, 1'b1, 1'b1);
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
      step();
      checkOutput("postflush", 1'b0, '0, '0, 0, 1'b1, 1'b1);

      // Asynchronous reset between edges with two queued
      applyStimulus(1'b1, 6'd14, make_word(14), 1'b0, 1'b0);
      step();
      applyStimulus(1'b1, 6'd15, make_word(15), 1'b0, 1'b0);
      step();
      checkOutput("prereset", 1'b1, 6'd14, make_word(14), 2, 1'b1, 1'b1);
      applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("async_rst", 1'b0, '0, '0, 0, 1'b1, 1'b0);
      #1;
      rst = 1'b0;

      // mem_ready with nothing queued must not disturb the empty state
      step();
      checkOutput("idle_ready", 1'b0, '0, '0, 0, 1'b1, 1'b0);

      // Streaming ten words with the memory always ready; pointers wrap
      for (int k = 0; k < 10; k++) begin
         applyStimulus(1'b1, AW'(20 + k), make_word(20 + k), 1'b1, 1'b0);
         step();
         checkOutput($sformatf("stream%0d", k), 1'b1, AW'(20 + k),
                     make_word(20 + k), 1, 1'b1, 1'b0);
      end
      applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
      step();
      checkOutput("stream_end", 1'b0, '0, '0, 0, 1'b1, 1'b0);

      // Simultaneous push and pop at count 2 keeps occupancy and order
      applyStimulus(1'b1, 6'd30, make_word(30), 1'b0, 1'b0);
      step();
      applyStimulus(1'b1, 6'd31, make_word(31), 1'b0, 1'b0);
      step();
      applyStimulus(1'b1, 6'd32, make_word(32), 1'b1, 1'b0);
      step();
      checkOutput("pushpop", 1'b1, 6'd31, make_word(31), 2, 1'b1, 1'b0);
      applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
      step();
      checkOutput("pushpop_next", 1'b1, 6'd32, make_word(32), 1, 1'b1, 1'b0);
      step();
      checkOutput("pushpop_end", 1'b0, '0, '0, 0, 1'b1, 1'b0);

      // Full with a simultaneous pop: offered word still dropped
      for (int k = 40; k <= 43; k++) begin
         applyStimulus(1'b1, AW'(k), make_word(k), 1'b0, 1'b0);
         step();
      end
      applyStimulus(1'b1, 6'd44, make_word(44), 1'b1, 1'b0);
      step();
      checkOutput("full_pop", 1'b1, 6'd41, make_word(41), 3, 1'b1, 1'b1);
      applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
      step();
      checkOutput("full_pop_42", 1'b1, 6'd42, make_word(42), 2, 1'b1, 1'b1);
      step();
      checkOutput("full_pop_43", 1'b1, 6'd43, make_word(43), 1, 1'b1, 1'b1);
      step();
      checkOutput("full_pop_end", 1'b0, '0, '0, 0, 1'b1, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
